// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath it steers.
// The sequencer takes the slave view; the datapath (or bench) takes the master view.
interface control_sequencer_if;
   logic [3:0] i_OPCODE;
   logic       i_CARRY;
   logic       i_ZERO;

   logic       o_PC_OUTPUT;
   logic       o_PC_COUNT_ENABLE;
   logic       o_PC_JUMP;
   logic       o_MAR_LOAD;
   logic       o_RAM_OUTPUT;
   logic       o_RAM_LOAD;
   logic       o_IR_LOAD;
   logic       o_IR_OUTPUT;
   logic       o_A_LOAD;
   logic       o_A_OUTPUT;
   logic       o_B_LOAD;
   logic       o_ALU_OUTPUT;
   logic       o_ALU_SUB;
   logic       o_OUT_LOAD;
   logic       o_HALT;
   logic [2:0] o_STEP;

   modport slave (
      input  i_OPCODE, i_CARRY, i_ZERO,
      output o_PC_OUTPUT, o_PC_COUNT_ENABLE, o_PC_JUMP, o_MAR_LOAD,
             o_RAM_OUTPUT, o_RAM_LOAD, o_IR_LOAD, o_IR_OUTPUT,
             o_A_LOAD, o_A_OUTPUT, o_B_LOAD, o_ALU_OUTPUT, o_ALU_SUB,
             o_OUT_LOAD, o_HALT, o_STEP
   );

   modport master (
      output i_OPCODE, i_CARRY, i_ZERO,
      input  o_PC_OUTPUT, o_PC_COUNT_ENABLE, o_PC_JUMP, o_MAR_LOAD,
             o_RAM_OUTPUT, o_RAM_LOAD, o_IR_LOAD, o_IR_OUTPUT,
             o_A_LOAD, o_A_OUTPUT, o_B_LOAD, o_ALU_OUTPUT, o_ALU_SUB,
             o_OUT_LOAD, o_HALT, o_STEP
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore microcode sequencer for a simple 8-bit bus CPU (fetch T0/T1, execute T2..T4).
// Define CONDITIONAL_JUMP_EN to add JC (0x7) and JZ (0x8); otherwise they act as NOP.
module control_sequencer (
   input logic                i_CLOCK,
   input logic                i_CLEAR_n,
   control_sequencer_if.slave ctrl_io
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_T0     = 3'd1,
      S_T1     = 3'd2,
      S_T2     = 3'd3,
      S_T3     = 3'd4,
      S_T4     = 3'd5,
      S_HALTED = 3'd7
   } state_e;

   typedef struct packed {
      logic pc_output;
      logic pc_count_enable;
      logic pc_jump;
      logic mar_load;
      logic ram_output;
      logic ram_load;
      logic ir_load;
      logic ir_output;
      logic a_load;
      logic a_output;
      logic b_load;
      logic alu_output;
      logic alu_sub;
      logic out_load;
   } ctrl_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
`ifdef CONDITIONAL_JUMP_EN
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
`endif
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_e     state_q;
   state_e     state_d;
   ctrl_t      ctrl_c;
   logic       halt_c;
   logic [3:0] opcode;

   assign opcode = ctrl_io.i_OPCODE;

`ifndef CONDITIONAL_JUMP_EN
   logic unused_flags;
   assign unused_flags = ctrl_io.i_CARRY ^ ctrl_io.i_ZERO;
`endif

   always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Every instruction returns to T0 right after its last active step, so
   // the execute states only advance while the current opcode still needs them.
   always_comb begin
      state_d = state_q;
      ctrl_c  = '0;
      halt_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_T0;
         end

         S_T0: begin
            ctrl_c.pc_output = 1'b1;
            ctrl_c.mar_load  = 1'b1;
            state_d          = S_T1;
         end

         S_T1: begin
            ctrl_c.ram_output      = 1'b1;
            ctrl_c.ir_load         = 1'b1;
            ctrl_c.pc_count_enable = 1'b1;
            state_d                = S_T2;
         end

         S_T2: begin
            state_d = S_T0;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl_c.ir_output = 1'b1;
                  ctrl_c.mar_load  = 1'b1;
                  state_d          = S_T3;
               end
               OP_LDI: begin
                  ctrl_c.ir_output = 1'b1;
                  ctrl_c.a_load    = 1'b1;
               end
               OP_JMP: begin
                  ctrl_c.ir_output = 1'b1;
                  ctrl_c.pc_jump   = 1'b1;
               end
`ifdef CONDITIONAL_JUMP_EN
               OP_JC: begin
                  ctrl_c.ir_output = ctrl_io.i_CARRY;
                  ctrl_c.pc_jump   = ctrl_io.i_CARRY;
               end
               OP_JZ: begin
                  ctrl_c.ir_output = ctrl_io.i_ZERO;
                  ctrl_c.pc_jump   = ctrl_io.i_ZERO;
               end
`endif
               OP_OUT: begin
                  ctrl_c.a_output = 1'b1;
                  ctrl_c.out_load = 1'b1;
               end
               OP_HLT: begin
                  state_d = S_HALTED;
               end
               OP_NOP: begin
                  state_d = S_T0;
               end
               default: begin
                  state_d = S_T0;
               end
            endcase
         end

         S_T3: begin
            state_d = S_T0;
            case (opcode)
               OP_LDA: begin
                  ctrl_c.ram_output = 1'b1;
                  ctrl_c.a_load     = 1'b1;
               end
               OP_ADD: begin
                  ctrl_c.ram_output = 1'b1;
                  ctrl_c.b_load     = 1'b1;
                  state_d           = S_T4;
               end
               OP_SUB: begin
                  ctrl_c.ram_output = 1'b1;
                  ctrl_c.b_load     = 1'b1;
                  ctrl_c.alu_sub    = 1'b1;
                  state_d           = S_T4;
               end
               OP_STA: begin
                  ctrl_c.a_output = 1'b1;
                  ctrl_c.ram_load = 1'b1;
               end
               default: begin
                  state_d = S_T0;
               end
            endcase
         end

         S_T4: begin
            state_d = S_T0;
            case (opcode)
               OP_ADD: begin
                  ctrl_c.alu_output = 1'b1;
                  ctrl_c.a_load     = 1'b1;
               end
               OP_SUB: begin
                  ctrl_c.alu_output = 1'b1;
                  ctrl_c.a_load     = 1'b1;
                  ctrl_c.alu_sub    = 1'b1;
               end
               default: begin
                  state_d = S_T0;
               end
            endcase
         end

         S_HALTED: begin
            halt_c  = 1'b1;
            state_d = S_HALTED;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ctrl_io.o_PC_OUTPUT       = ctrl_c.pc_output;
   assign ctrl_io.o_PC_COUNT_ENABLE = ctrl_c.pc_count_enable;
   assign ctrl_io.o_PC_JUMP         = ctrl_c.pc_jump;
   assign ctrl_io.o_MAR_LOAD        = ctrl_c.mar_load;
   assign ctrl_io.o_RAM_OUTPUT      = ctrl_c.ram_output;
   assign ctrl_io.o_RAM_LOAD        = ctrl_c.ram_load;
   assign ctrl_io.o_IR_LOAD         = ctrl_c.ir_load;
   assign ctrl_io.o_IR_OUTPUT       = ctrl_c.ir_output;
   assign ctrl_io.o_A_LOAD          = ctrl_c.a_load;
   assign ctrl_io.o_A_OUTPUT        = ctrl_c.a_output;
   assign ctrl_io.o_B_LOAD          = ctrl_c.b_load;
   assign ctrl_io.o_ALU_OUTPUT      = ctrl_c.alu_output;
   assign ctrl_io.o_ALU_SUB         = ctrl_c.alu_sub;
   assign ctrl_io.o_OUT_LOAD        = ctrl_c.out_load;
   assign ctrl_io.o_HALT            = halt_c;
   assign ctrl_io.o_STEP            = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction runs, async
// reset cases, halt behaviour and a random opcode/flag stream with invariant checks.
module tb_control_sequencer;

   localparam int W = 18;

   // Control bit positions inside the 14-bit control field.
   localparam logic [13:0] M_PC_OUT  = 14'b10000000000000;
   localparam logic [13:0] M_PC_CNT  = 14'b01000000000000;
   localparam logic [13:0] M_PC_JMP  = 14'b00100000000000;
   localparam logic [13:0] M_MAR_LD  = 14'b00010000000000;
   localparam logic [13:0] M_RAM_OUT = 14'b00001000000000;
   localparam logic [13:0] M_RAM_LD  = 14'b00000100000000;
   localparam logic [13:0] M_IR_LD   = 14'b00000010000000;
   localparam logic [13:0] M_IR_OUT  = 14'b00000001000000;
   localparam logic [13:0] M_A_LD    = 14'b00000000100000;
   localparam logic [13:0] M_A_OUT   = 14'b00000000010000;
   localparam logic [13:0] M_B_LD    = 14'b00000000001000;
   localparam logic [13:0] M_ALU_OUT = 14'b00000000000100;
   localparam logic [13:0] M_ALU_SUB = 14'b00000000000010;
   localparam logic [13:0] M_OUT_LD  = 14'b00000000000001;

   logic clk;
   logic rst_n;
   control_sequencer_if ifc ();

   control_sequencer dut (
      .i_CLOCK   (clk),
      .i_CLEAR_n (rst_n),
      .ctrl_io   (ifc.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   int m_step = 0;
   int last_step = 0;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: step of the last active execute state per opcode.
   function automatic int model_last(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   function automatic int model_next(input int step, input logic [3:0] op);
      if (step == 0) return 1;
      if (step == 7) return 7;
      if (step == 3 && op == 4'hF) return 7;
      if (step >= model_last(op)) return 1;
      return step + 1;
   endfunction

   function automatic logic [W-1:0] model_out(input int step, input logic [3:0] op,
                                              input logic c, input logic z);
      logic [13:0] m;
      logic [2:0]  s;
      m = '0;
      s = 3'(step);
      case (step)
         1: m = M_PC_OUT | M_MAR_LD;
         2: m = M_RAM_OUT | M_IR_LD | M_PC_CNT;
         3: begin
            case (op)
               4'h1, 4'h2, 4'h3, 4'h4: m = M_IR_OUT | M_MAR_LD;
               4'h5: m = M_IR_OUT | M_A_LD;
               4'h6: m = M_IR_OUT | M_PC_JMP;
`ifdef CONDITIONAL_JUMP_EN
               4'h7: m = c ? (M_IR_OUT | M_PC_JMP) : 14'd0;
               4'h8: m = z ? (M_IR_OUT | M_PC_JMP) : 14'd0;
`endif
               4'hE: m = M_A_OUT | M_OUT_LD;
               default: m = '0;
            endcase
         end
         4: begin
            case (op)
               4'h1: m = M_RAM_OUT | M_A_LD;
               4'h2: m = M_RAM_OUT | M_B_LD;
               4'h3: m = M_RAM_OUT | M_B_LD | M_ALU_SUB;
               4'h4: m = M_A_OUT | M_RAM_LD;
               default: m = '0;
            endcase
         end
         5: begin
            case (op)
               4'h2: m = M_ALU_OUT | M_A_LD;
               4'h3: m = M_ALU_OUT | M_A_LD | M_ALU_SUB;
               default: m = '0;
            endcase
         end
         default: m = '0;
      endcase
`ifndef CONDITIONAL_JUMP_EN
      if (c ^ z ^ c ^ z) m = m;
`endif
      return {(step == 7), s, m};
   endfunction

   function automatic logic [W-1:0] dut_vec();
      return {ifc.o_HALT, ifc.o_STEP,
              ifc.o_PC_OUTPUT, ifc.o_PC_COUNT_ENABLE, ifc.o_PC_JUMP, ifc.o_MAR_LOAD,
              ifc.o_RAM_OUTPUT, ifc.o_RAM_LOAD, ifc.o_IR_LOAD, ifc.o_IR_OUTPUT,
              ifc.o_A_LOAD, ifc.o_A_OUTPUT, ifc.o_B_LOAD, ifc.o_ALU_OUTPUT,
              ifc.o_ALU_SUB, ifc.o_OUT_LOAD};
   endfunction

   // scoreboard pop plus bus-drive and PC-control invariants
   task automatic compare_now(input string tag);
      logic [W-1:0] exp;
      logic [4:0]   drivers;
      logic         one_drv;
      logic         no_clash;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_empty_q"}, 18'd0, 18'd1);
         return;
      end
      exp = exp_q.pop_front();
      check_eq(tag, dut_vec(), exp);
      drivers  = {ifc.o_PC_OUTPUT, ifc.o_RAM_OUTPUT, ifc.o_IR_OUTPUT,
                  ifc.o_A_OUTPUT, ifc.o_ALU_OUTPUT};
      one_drv  = ($countones(drivers) <= 1);
      no_clash = !(ifc.o_PC_JUMP && ifc.o_PC_COUNT_ENABLE);
      check_eq({tag, "_one_bus_driver"}, {17'd0, one_drv}, 18'd1);
      check_eq({tag, "_jump_vs_count"}, {17'd0, no_clash}, 18'd1);
   endtask

   // driver: one clock cycle with the given opcode and flags
   task automatic run_cycle(input logic [3:0] op, input logic c, input logic z, input string tag);
      @(negedge clk);
      ifc.i_OPCODE = op;
      ifc.i_CARRY  = c;
      ifc.i_ZERO   = z;
      #1;
      exp_q.push_back(model_out(m_step, op, c, z));
      compare_now(tag);
      last_step = m_step;
      m_step    = model_next(m_step, op);
   endtask

   // async reset pulse starting mid-cycle, released just after a rising edge
   task automatic reset_pulse(input string tag);
      #2;
      rst_n  = 1'b0;
      m_step = 0;
      #1;
      exp_q.push_back(model_out(0, ifc.i_OPCODE, ifc.i_CARRY, ifc.i_ZERO));
      compare_now({tag, "_async"});
      @(posedge clk);
      #1;
      exp_q.push_back(model_out(0, ifc.i_OPCODE, ifc.i_CARRY, ifc.i_ZERO));
      compare_now({tag, "_held"});
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] op;
      int guard;
      rst_n        = 1'b0;
      ifc.i_OPCODE = 4'h0;
      ifc.i_CARRY  = 1'b0;
      ifc.i_ZERO   = 1'b0;

      #2;
      check_eq("reset_state", dut_vec(), 18'd0);
      @(posedge clk);
      #1;
      check_eq("reset_state_edge", dut_vec(), 18'd0);
      #1;
      rst_n = 1'b1;

      // NOP loop: steps 0,1,2,3,1,2,3
      for (int i = 0; i < 7; i++) run_cycle(4'h0, 1'b0, 1'b0, "nop");
      check_eq("nop_final_step", {15'd0, ifc.o_STEP}, 18'd3);

      // SUB: T3/T4 carry ALU_SUB, then back to T0
      for (int i = 0; i < 6; i++) run_cycle(4'h3, 1'b0, 1'b0, "sub");

      // every non-halting opcode, one full pass plus margin
      for (int o = 0; o < 15; o++) begin
         op = 4'(o);
         for (int i = 0; i < 6; i++) run_cycle(op, 1'b1, 1'b0, "opcode_sweep");
      end

      // conditional jumps: flag set then cleared
      reset_pulse("rst_before_jc");
      for (int i = 0; i < 4; i++) run_cycle(4'h7, 1'b1, 1'b0, "jc_carry1");
      for (int i = 0; i < 3; i++) run_cycle(4'h7, 1'b0, 1'b0, "jc_carry0");
      for (int i = 0; i < 3; i++) run_cycle(4'h8, 1'b0, 1'b1, "jz_zero1");
      for (int i = 0; i < 3; i++) run_cycle(4'h8, 1'b0, 1'b0, "jz_zero0");

      // HLT: reach HALTED and stay there for 20 cycles
      guard = 0;
      while (m_step != 7 && guard < 10) begin
         run_cycle(4'hF, 1'b0, 1'b0, "hlt_enter");
         guard++;
      end
      check_eq("hlt_reached", {17'd0, (m_step == 7)}, 18'd1);
      for (int i = 0; i < 20; i++) run_cycle(4'($urandom_range(0, 15)), 1'b1, 1'b1, "halted");
      reset_pulse("rst_from_halt");
      run_cycle(4'h0, 1'b0, 1'b0, "after_halt_idle");
      run_cycle(4'h0, 1'b0, 1'b0, "after_halt_t0");

      // ADD interrupted by reset in T3
      guard = 0;
      do begin
         run_cycle(4'h2, 1'b0, 1'b0, "add_to_t3");
         guard++;
      end while (last_step != 4 && guard < 20);
      check_eq("add_reached_t3", {15'd0, 3'(last_step)}, 18'd4);
      reset_pulse("rst_mid_t3");
      run_cycle(4'h2, 1'b0, 1'b0, "restart_idle");
      run_cycle(4'h2, 1'b0, 1'b0, "restart_t0");

      // random opcode/flag stream
      for (int i = 0; i < 10000; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h0;
         if (m_step == 7 || $urandom_range(0, 499) == 0) begin
            reset_pulse("rnd_reset");
         end else begin
            run_cycle(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
         end
      end

      check_eq("queue_drained", {17'd0, (exp_q.size() == 0)}, 18'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none; opcode width is fixed at 4 bits.
REQ-002 i_CLOCK  input  1  system clock; all state changes on rising edge.
REQ-003 i_CLEAR_n  input  1  asynchronous active-low reset.
REQ-004 i_OPCODE  input  4  instruction register opcode nibble; sampled combinationally from step T2 onward.
REQ-005 i_CARRY, i_ZERO  input  1 each  ALU flag register outputs.
REQ-006 o_PC_OUTPUT, o_PC_COUNT_ENABLE, o_PC_JUMP  output  1 each  program counter controls (bus drive, increment, load from bus).
REQ-007 o_MAR_LOAD, o_RAM_OUTPUT, o_RAM_LOAD  output  1 each  memory address register load, RAM bus drive, RAM write.
REQ-008 o_IR_LOAD, o_IR_OUTPUT  output  1 each  instruction register load, operand nibble bus drive.
REQ-009 o_A_LOAD, o_A_OUTPUT, o_B_LOAD, o_ALU_OUTPUT, o_ALU_SUB, o_OUT_LOAD  output  1 each  datapath controls.
REQ-010 o_HALT  output  1  high while halted; o_STEP  output  3  current step (0=IDLE, 1..5=T0..T4, 7=HALTED).

Function
REQ-011 The sequencer SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, HALTED; outputs SHALL decode combinationally from state and i_OPCODE.
REQ-012 IDLE: all outputs 0 except o_STEP=0; next state T0 unconditionally.
REQ-013 T0: o_PC_OUTPUT, o_MAR_LOAD; next T1.
REQ-014 T1: o_RAM_OUTPUT, o_IR_LOAD, o_PC_COUNT_ENABLE; next T2.
REQ-015 Opcodes 0x1 LDA: T2 IR_OUTPUT+MAR_LOAD; T3 RAM_OUTPUT+A_LOAD.
REQ-016 0x2 ADD: T2 IR_OUTPUT+MAR_LOAD; T3 RAM_OUTPUT+B_LOAD; T4 ALU_OUTPUT+A_LOAD.
REQ-017 0x3 SUB: as ADD with o_ALU_SUB high in T3 and T4.
REQ-018 0x4 STA: T2 IR_OUTPUT+MAR_LOAD; T3 A_OUTPUT+RAM_LOAD.
REQ-019 0x5 LDI: T2 IR_OUTPUT+A_LOAD. 0x6 JMP: T2 IR_OUTPUT+PC_JUMP. 0xE OUT: T2 A_OUTPUT+OUT_LOAD.
REQ-020 0xF HLT: T2 asserts no datapath control; next state HALTED.
REQ-021 0x0 NOP, and every opcode not listed (including 0x7/0x8 when the Configuration feature is compiled out), SHALL assert nothing in T2 and return to T0.
REQ-022 Variable length: the state after an instruction's last active step SHALL be T0 (LDI/JMP/OUT/NOP: T2->T0; LDA/STA: T3->T0; ADD/SUB: T4->T0).
REQ-023 HALTED: all controls 0, o_HALT=1; remains HALTED until reset.
REQ-024 At most one of the *_OUTPUT signals SHALL be high in any state; bench asserts this as an invariant.
REQ-025 o_PC_JUMP and o_PC_COUNT_ENABLE SHALL never be high in the same state.

Reset
REQ-026 i_CLEAR_n low SHALL force state to IDLE immediately, independent of clock, including mid-instruction and from HALTED.
REQ-027 During and after reset until the first rising edge after release: all control outputs 0, o_HALT=0, o_STEP=0.

Configuration
REQ-028 Macro CONDITIONAL_JUMP_EN defined: 0x7 JC asserts IR_OUTPUT+PC_JUMP in T2 only if i_CARRY=1, 0x8 JZ likewise on i_ZERO=1; otherwise nothing; next state T0 in both cases.
REQ-029 CONDITIONAL_JUMP_EN undefined: 0x7 and 0x8 SHALL behave as NOP per REQ-021.

Verification
REQ-030 Release reset, i_OPCODE=0x0 -> o_STEP 0,1,2,3,1,2,3...; T0 asserts PC_OUTPUT+MAR_LOAD; T1 asserts RAM_OUTPUT+IR_LOAD+PC_COUNT_ENABLE.
REQ-031 i_OPCODE=0x3 -> T3 RAM_OUTPUT+B_LOAD+ALU_SUB, T4 ALU_OUTPUT+A_LOAD+ALU_SUB, then o_STEP=1.
REQ-032 i_OPCODE=0x7, i_CARRY=1 then 0 -> with CONDITIONAL_JUMP_EN: PC_JUMP high in T2 first pass only; without: never high.
REQ-033 i_OPCODE=0xF -> after T2, o_HALT=1, o_STEP=7, all controls 0 for 20 cycles; pulse i_CLEAR_n low -> o_HALT=0, o_STEP=0 asynchronously.
REQ-034 i_OPCODE=0x2, assert i_CLEAR_n low mid-T3 -> outputs 0 immediately; after release, sequence restarts at IDLE then T0.
REQ-035 Random opcode/flag stream, 10k cycles -> REQ-024 and REQ-025 invariants never violated.
